// File: rtl/vending_machine_param.sv
// Parametrised coin-credit vending controller with stock tracking, restock and a ship/ship_ack handshake.
// Optional inactivity auto-refund is enabled by defining VM_TIMEOUT_EN.
module vending_machine_param #(
  parameter int PRICE       = 7,
  parameter int CREDIT_W    = 8,
  parameter int STOCK_W     = 6,
  parameter int INIT_STOCK  = 10,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                cancel,
  input  logic                ship_ack,
  input  logic                restock,
  input  logic [STOCK_W-1:0]  restock_qty,
  output logic                ship,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change,
  output logic                refund_valid,
  output logic [CREDIT_W-1:0] refund,
  output logic [CREDIT_W-1:0] credit,
  output logic [STOCK_W-1:0]  stock,
  output logic                sold_out
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND} state_t;

  localparam logic [CREDIT_W:0] PRICE_EXT = (CREDIT_W+1)'(PRICE);

  state_t              state, state_d;
  logic [CREDIT_W-1:0] coin_units;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] refund_amt;
  logic [CREDIT_W-1:0] credit_d, change_d, refund_d;
  logic                ship_d, change_valid_d, refund_valid_d;
  logic                sale;
  logic [STOCK_W:0]    stock_sum;
  logic [STOCK_W-1:0]  stock_d;
  logic                timeout;

  always_comb begin
    case (coin_type)
      2'b00:   coin_units = CREDIT_W'(1);
      2'b01:   coin_units = CREDIT_W'(2);
      2'b10:   coin_units = CREDIT_W'(4);
      default: coin_units = CREDIT_W'(10);
    endcase
  end

  assign sum        = {1'b0, credit} + {1'b0, coin_units};
  assign refund_amt = credit + (coin_valid ? coin_units : '0);

`ifdef VM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt;

  // A coin arriving in the expiry cycle takes precedence over the auto-refund.
  assign timeout = (state == COLLECT) && !coin_valid && (idle_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst)
      idle_cnt <= '0;
    else if (coin_valid || (state != COLLECT) || timeout)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end
`else
  // No inactivity timer in this build; credit is held indefinitely.
  assign timeout = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    state_d        = state;
    credit_d       = credit;
    ship_d         = ship;
    change_d       = change;
    change_valid_d = 1'b0;
    refund_d       = refund;
    refund_valid_d = 1'b0;
    sale           = 1'b0;
    case (state)
      VEND: begin
        if (coin_valid) begin
          refund_d       = coin_units;
          refund_valid_d = 1'b1;
        end
        if (ship_ack) begin
          ship_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        if (cancel || timeout) begin
          if (refund_amt != '0) begin
            refund_d       = refund_amt;
            refund_valid_d = 1'b1;
          end
          credit_d = '0;
          state_d  = IDLE;
        end else if (coin_valid) begin
          if (stock == '0) begin
            refund_d       = coin_units;
            refund_valid_d = 1'b1;
          end else if (sum < PRICE_EXT) begin
            credit_d = sum[CREDIT_W-1:0];
            state_d  = COLLECT;
          end else begin
            ship_d         = 1'b1;
            change_d       = CREDIT_W'(sum - PRICE_EXT);
            change_valid_d = 1'b1;
            credit_d       = '0;
            sale           = 1'b1;
            state_d        = VEND;
          end
        end
      end
    endcase
  end

  // Restock and a same-cycle sale both apply; result saturates at the counter maximum.
  assign stock_sum = {1'b0, stock} - {{STOCK_W{1'b0}}, sale}
                   + (restock ? {1'b0, restock_qty} : '0);
  assign stock_d   = stock_sum[STOCK_W] ? '1 : stock_sum[STOCK_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      credit       <= '0;
      stock        <= STOCK_W'(INIT_STOCK);
      ship         <= 1'b0;
      change_valid <= 1'b0;
      change       <= '0;
      refund_valid <= 1'b0;
      refund       <= '0;
      sold_out     <= (INIT_STOCK == 0);
    end else begin
      state        <= state_d;
      credit       <= credit_d;
      stock        <= stock_d;
      ship         <= ship_d;
      change_valid <= change_valid_d;
      change       <= change_d;
      refund_valid <= refund_valid_d;
      refund       <= refund_d;
      sold_out     <= (stock_d == '0);
    end
  end

endmodule
